pred_upd_ctrl: RTL and testbench

- Sits between EX and the branch predictor and PC_REG.
- Buffers resolved branch outcomes from EX in a small FIFO and drains them one per cycle into the predictor's single update port.
- Detects mispredictions and sequences the front-end flush/redirect through a small FSM.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/pred_upd_ctrl.sv | 157 +++++++++++++++
 tb/tb_pred_upd_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_upd_ctrl.sv
// Branch resolution buffer between EX and the predictor: queues resolved branches,
// drains one per cycle into the predictor update port, and sequences mispredict flushes.
module pred_upd_ctrl #(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_addr,
  input  logic        upd_hold,
  output logic        ex_stall,
  output logic        is_br,
  output logic [31:0] addr_ex,
  output logic [31:0] jmp_addr,
  output logic        jmp,
  output logic        flush,
  output logic [31:0] redirect_addr,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] FCNT_INIT = CNT_W'(FLUSH_CYC - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } entry_t;

  typedef enum logic {IDLE, FLUSH} state_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             is_br_q, is_br_d, jmp_q, jmp_d;
  logic [31:0]      addr_ex_q, addr_ex_d, jmp_addr_q, jmp_addr_d;
  logic [31:0]      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic        empty, deq, stall, acc, mispred;
  logic [31:0] next_pc;

  // While flushing, EX carries wrong-path instructions, so nothing from it is accepted.
  assign empty   = (count_q == '0);
  assign deq     = !empty && !upd_hold;
  assign stall   = (count_q == FULL_CNT) && !deq;
  assign acc     = ex_valid && ex_is_br && (state_q == IDLE) && !stall;
  assign mispred = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_target != ex_pred_addr));
  assign next_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    is_br_d    = deq;
    addr_ex_d  = addr_ex_q;
    jmp_addr_d = jmp_addr_q;
    jmp_d      = jmp_q;
    br_cnt_d   = br_cnt_q;
    mis_cnt_d  = mis_cnt_q;
    if (acc) begin
      mem_d[wptr_q] = '{pc: ex_pc, target: ex_target, taken: ex_taken};
      wptr_d        = wptr_q + PTR_W'(1);
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
      if (mispred && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 32'd1;
    end
    // The head is read from the registered array, so a same-cycle write to that slot is safe.
    if (deq) begin
      rptr_d     = rptr_q + PTR_W'(1);
      addr_ex_d  = mem_q[rptr_q].pc;
      jmp_addr_d = mem_q[rptr_q].target;
      jmp_d      = mem_q[rptr_q].taken;
    end
    case ({acc, deq})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    redirect_d = redirect_q;
    case (state_q)
      IDLE: begin
        if (acc && mispred) begin
          state_d    = FLUSH;
          fcnt_d     = FCNT_INIT;
          redirect_d = next_pc;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      fcnt_q     <= '0;
      redirect_q <= '0;
      is_br_q    <= 1'b0;
      addr_ex_q  <= '0;
      jmp_addr_q <= '0;
      jmp_q      <= 1'b0;
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      redirect_q <= redirect_d;
      is_br_q    <= is_br_d;
      addr_ex_q  <= addr_ex_d;
      jmp_addr_q <= jmp_addr_d;
      jmp_q      <= jmp_d;
      br_cnt_q   <= br_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign ex_stall      = stall;
  assign is_br         = is_br_q;
  assign addr_ex       = addr_ex_q;
  assign jmp_addr      = jmp_addr_q;
  assign jmp           = jmp_q;
  assign flush         = (state_q == FLUSH);
  assign redirect_addr = redirect_q;
  assign br_cnt        = br_cnt_q;
  assign mis_cnt       = mis_cnt_q;

endmodule

// File: tb/tb_pred_upd_ctrl.sv
// Self-checking bench for pred_upd_ctrl: predictor updates are checked through a
// scoreboard queue, flush/redirect/counters/stall by inline checks in each scenario task.
module tb_pred_upd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_br, ex_taken, ex_pred_taken, upd_hold;
  logic [31:0] ex_pc, ex_target, ex_pred_addr;
  logic        ex_stall, is_br, jmp, flush;
  logic [31:0] addr_ex, jmp_addr, redirect_addr, br_cnt, mis_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  upd_t        sb[$];
  upd_t        mon_exp;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = '0;
  logic [31:0] exp_mis = '0;

  pred_upd_ctrl #(.DEPTH(4), .PTR_W(2), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pred_addr(ex_pred_addr),
    .upd_hold(upd_hold), .ex_stall(ex_stall), .is_br(is_br), .addr_ex(addr_ex),
    .jmp_addr(jmp_addr), .jmp(jmp), .flush(flush), .redirect_addr(redirect_addr),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  // Every predictor update must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && is_br === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL upd_unexpected: got is_br=1 addr_ex=%h jmp_addr=%h, expected no update", addr_ex, jmp_addr);
      end else begin
        mon_exp = sb.pop_front();
        if ({addr_ex, jmp_addr, jmp} !== mon_exp) begin
          errors++;
          $display("[TB] FAIL upd_order: got addr_ex=%h jmp_addr=%h jmp=%b, expected %h %h %b",
                   addr_ex, jmp_addr, jmp, mon_exp.pc, mon_exp.target, mon_exp.taken);
        end
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic set_idle();
    ex_valid = 1'b0; ex_is_br = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_addr = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                       input logic ptk, input logic [31:0] paddr);
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc; ex_target = tgt;
    ex_taken = tk; ex_pred_taken = ptk; ex_pred_addr = paddr;
  endtask

  // Issue a branch the bench expects to be accepted, and record its expected effects.
  task automatic issue_acc(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic ptk, input logic [31:0] paddr);
    issue(pc, tgt, tk, ptk, paddr);
    sb.push_back('{pc: pc, target: tgt, taken: tk});
    exp_br = sat_inc(exp_br);
    if ((tk != ptk) || (tk && ptk && (tgt != paddr))) exp_mis = sat_inc(exp_mis);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d updates pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; upd_hold = 1'b0; set_idle();
    #12;
    checks++;
    if ({ex_stall, is_br, addr_ex, jmp_addr, jmp, flush, redirect_addr, br_cnt, mis_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got stall=%b is_br=%b flush=%b br=%h mis=%h redir=%h, expected all 0",
               ex_stall, is_br, flush, br_cnt, mis_cnt, redirect_addr);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_correct_taken();
    @(negedge clk); issue_acc(32'h100, 32'h180, 1'b1, 1'b1, 32'h180);
    @(negedge clk); set_idle();
    checks++;
    if ({flush, is_br, br_cnt, mis_cnt} !== {1'b0, 1'b0, exp_br, exp_mis}) begin
      errors++;
      $display("[TB] FAIL correct_t1: got flush=%b is_br=%b br=%h mis=%h, expected 0 0 %h %h",
               flush, is_br, br_cnt, mis_cnt, exp_br, exp_mis);
    end
    @(negedge clk);
    checks++;
    if (is_br !== 1'b1) begin
      errors++;
      $display("[TB] FAIL correct_latency: got is_br=%b two cycles after issue, expected 1", is_br);
    end
    drain();
  endtask

  task automatic test_dir_mispredict();
    @(negedge clk); issue_acc(32'h200, 32'h280, 1'b0, 1'b1, 32'h280);
    @(negedge clk); issue(32'h900, 32'h990, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({flush, redirect_addr, mis_cnt} !== {1'b1, 32'h204, exp_mis}) begin
      errors++;
      $display("[TB] FAIL dir_flush1: got flush=%b redir=%h mis=%h, expected 1 00000204 %h",
               flush, redirect_addr, mis_cnt, exp_mis);
    end
    @(negedge clk); issue(32'h940, 32'h9a0, 1'b0, 1'b1, 32'h0);
    checks++;
    if ({flush, redirect_addr} !== {1'b1, 32'h204}) begin
      errors++;
      $display("[TB] FAIL dir_flush2: got flush=%b redir=%h, expected 1 00000204", flush, redirect_addr);
    end
    @(negedge clk); set_idle();
    checks++;
    if ({flush, br_cnt, mis_cnt} !== {1'b0, exp_br, exp_mis}) begin
      errors++;
      $display("[TB] FAIL dir_after: got flush=%b br=%h mis=%h, expected 0 %h %h",
               flush, br_cnt, mis_cnt, exp_br, exp_mis);
    end
    drain();
  endtask

  task automatic test_target_mispredict();
    @(negedge clk); issue_acc(32'h300, 32'h400, 1'b1, 1'b1, 32'h500);
    @(negedge clk); set_idle();
    checks++;
    if ({flush, redirect_addr, mis_cnt} !== {1'b1, 32'h400, exp_mis}) begin
      errors++;
      $display("[TB] FAIL tgt_flush: got flush=%b redir=%h mis=%h, expected 1 00000400 %h",
               flush, redirect_addr, mis_cnt, exp_mis);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tgt_flush_end: got flush=%b, expected 0", flush);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); upd_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_acc(32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i) * 32'h10, i[0], i[0],
                32'h2000 + 32'(i) * 32'h10);
      @(negedge clk);
    end
    issue(32'h1040, 32'h2040, 1'b1, 1'b1, 32'h2040);
    #1;
    checks++;
    if (ex_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_stall_full: got ex_stall=%b, expected 1", ex_stall);
    end
    upd_hold = 1'b0;
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_stall_release: got ex_stall=%b, expected 0", ex_stall);
    end
    sb.push_back('{pc: 32'h1040, target: 32'h2040, taken: 1'b1});
    exp_br = sat_inc(exp_br);
    @(negedge clk); set_idle();
    checks++;
    if (br_cnt !== exp_br) begin
      errors++;
      $display("[TB] FAIL b2b_br_cnt: got %h, expected %h", br_cnt, exp_br);
    end
    drain();
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk); upd_hold = 1'b1;
    issue(32'h700, 32'h780, 1'b1, 1'b1, 32'h780);
    @(negedge clk); issue(32'h710, 32'h790, 1'b0, 1'b0, 32'h0);
    @(negedge clk); issue(32'h720, 32'h7a0, 1'b1, 1'b0, 32'h0);
    exp_br = sat_inc(sat_inc(sat_inc(exp_br)));
    exp_mis = sat_inc(exp_mis);
    @(negedge clk); set_idle();
    checks++;
    if ({flush, br_cnt, mis_cnt} !== {1'b1, exp_br, exp_mis}) begin
      errors++;
      $display("[TB] FAIL rstmid_pre: got flush=%b br=%h mis=%h, expected 1 %h %h",
               flush, br_cnt, mis_cnt, exp_br, exp_mis);
    end
    #2 rst = 1'b0;
    #1;
    exp_br = '0; exp_mis = '0;
    checks++;
    if ({flush, is_br, br_cnt, mis_cnt, ex_stall, redirect_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got flush=%b is_br=%b br=%h mis=%h stall=%b redir=%h, expected all 0",
               flush, is_br, br_cnt, mis_cnt, ex_stall, redirect_addr);
    end
    @(negedge clk); rst = 1'b1; upd_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (is_br !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rstmid_stale: got is_br=%b addr_ex=%h after reset, expected 0", is_br, addr_ex);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.br_cnt_q = 32'hFFFF_FFFD;
    force dut.mis_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    release dut.mis_cnt_q;
    exp_br = 32'hFFFF_FFFD; exp_mis = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      issue_acc(32'h800 + 32'(i) * 32'h4, 32'h880, 1'b1, 1'b1, 32'h880);
      @(negedge clk); set_idle();
      checks++;
      if (br_cnt !== exp_br) begin
        errors++;
        $display("[TB] FAIL sat_br_%0d: got %h, expected %h", i, br_cnt, exp_br);
      end
    end
    for (int i = 0; i < 2; i++) begin
      issue_acc(32'h900 + 32'(i) * 32'h4, 32'h980, 1'b0, 1'b1, 32'h980);
      @(negedge clk); set_idle();
      checks++;
      if ({br_cnt, mis_cnt} !== {exp_br, exp_mis}) begin
        errors++;
        $display("[TB] FAIL sat_mis_%0d: got br=%h mis=%h, expected %h %h", i, br_cnt, mis_cnt, exp_br, exp_mis);
      end
      repeat (3) @(negedge clk);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_dir_mispredict();
    test_target_mispredict();
    test_back_to_back();
    test_reset_mid_flush();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
